// File: rtl/sub_bytes_state_seq.sv
// Sequential AES SubBytes stage: latches a 128-bit state and substitutes it
// BYTES_PER_CYCLE bytes per clock through parallel S-box lanes, valid/ready on both sides.
module sub_bytes_state_seq #(
    parameter int unsigned BYTES_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int unsigned GROUPS = 16 / BYTES_PER_CYCLE;
    localparam int unsigned CntW   = $clog2(GROUPS) + 1;

    if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
          BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
        $error("sub_bytes_state_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    // Forward AES S-box, entry 0 leftmost.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    // Byte 0 (FIPS-197 order) is index 0, i.e. the MSB of the flat state.
    logic [0:15][7:0] work_q, work_d;
    logic [0:15][7:0] result_q, result_d;

    logic [3:0] lane_idx [BYTES_PER_CYCLE];
    logic [7:0] lane_in  [BYTES_PER_CYCLE];
    logic [7:0] lane_out [BYTES_PER_CYCLE];

    for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_lane
        // Only meaningful in RUN, where cnt*BPC+j never exceeds 15.
        assign lane_idx[j] = 4'(cnt_q * BYTES_PER_CYCLE + j);
        assign lane_in[j]  = work_q[lane_idx[j]];
        assign lane_out[j] = sbox(lane_in[j]);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        result_d = result_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    work_d  = in_state;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
                    result_d[lane_idx[j]] = lane_out[j];
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(GROUPS - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            work_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign out_state = result_q;

endmodule

// File: tb/tb_sub_bytes_state_seq.sv
// Bench for sub_bytes_state_seq: three instances (BPC=1,4,16), vector table plus
// handshake corner sequences, expected states queued on acceptance and popped on output.
module tb_sub_bytes_state_seq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] in_state  [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] out_state [3];
    logic         busy      [3];

    always #5 clk = ~clk;

    sub_bytes_state_seq #(.BYTES_PER_CYCLE(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_state(in_state[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_state(out_state[0]), .busy(busy[0])
    );
    sub_bytes_state_seq #(.BYTES_PER_CYCLE(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_state(in_state[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_state(out_state[1]), .busy(busy[1])
    );
    sub_bytes_state_seq #(.BYTES_PER_CYCLE(16)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_state(in_state[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_state(out_state[2]), .busy(busy[2])
    );

    typedef struct {
        int           inst;
        logic [127:0] st;
        logic [127:0] exp;
    } vec_t;

    localparam logic [127:0] FipsIn  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FipsOut = 128'hd42711aee0bf98f1b8b45de51e415230;

    int           passed = 0;
    int           total  = 0;
    logic [127:0] sb [$];

    function automatic logic [127:0] splat(input logic [7:0] b);
        return {16{b}};
    endfunction

    function automatic int groups_of(input int i);
        return (i == 0) ? 16 : (i == 1) ? 4 : 1;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic accept(input int i, input logic [127:0] st, input logic [127:0] exp);
        check("accept_in_ready", in_ready[i], 1);
        in_valid[i] = 1'b1;
        in_state[i] = st;
        @(posedge clk); #1;
        in_valid[i] = 1'b0;
        in_state[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        sb.push_back(exp);
        check("run_busy", busy[i], 1);
        check("run_in_ready", in_ready[i], 0);
    endtask

    task automatic wait_valid(input int i, output int edges);
        edges = 0;
        while (!out_valid[i] && edges < 64) begin
            @(posedge clk); #1;
            edges++;
        end
        check("out_valid_seen", out_valid[i], 1);
    endtask

    task automatic compare_out(input int i, input string name);
        logic [127:0] exp;
        if (sb.size() == 0) begin
            check("sb_not_empty", 0, 1);
        end else begin
            exp = sb.pop_front();
            check(name, out_state[i], exp);
        end
    endtask

    task automatic collect(input int i, input string name);
        compare_out(i, name);
        out_ready[i] = 1'b1;
        @(posedge clk); #1;
        out_ready[i] = 1'b0;
        check("post_out_valid", out_valid[i], 0);
        check("post_in_ready", in_ready[i], 1);
    endtask

    task automatic run_block(input int i, input logic [127:0] st, input logic [127:0] exp,
                             input string name);
        int edges;
        accept(i, st, exp);
        wait_valid(i, edges);
        check("latency", edges, groups_of(i));
        collect(i, name);
    endtask

    initial begin
        vec_t         tbl [7];
        int           edges;
        logic [127:0] hold;
        logic         ok;
        logic [127:0] blk [3];
        int           times [3];
        int           k;
        int           nout;
        logic         acc;

        tbl[0] = '{0, splat(8'h19), splat(8'hd4)};
        tbl[1] = '{0, splat(8'h7c), splat(8'h10)};
        tbl[2] = '{0, splat(8'h00), splat(8'h63)};
        tbl[3] = '{0, splat(8'hff), splat(8'h16)};
        tbl[4] = '{0, FipsIn, FipsOut};
        tbl[5] = '{1, FipsIn, FipsOut};
        tbl[6] = '{2, FipsIn, FipsOut};

        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b0;
            in_state[i]  = '0;
        end

        // Reset state
        rst_n = 1'b0;
        #12;
        check("rst_out_valid", out_valid[0], 0);
        check("rst_out_state", out_state[0], 0);
        check("rst_busy", busy[2], 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready[0], 1);

        // Vector table
        for (int v = 0; v < 7; v++) begin
            run_block(tbl[v].inst, tbl[v].st, tbl[v].exp, $sformatf("vec%0d", v));
        end

        // Backpressure on BPC=4: output held, inputs ignored
        accept(1, splat(8'h7c), splat(8'h10));
        wait_valid(1, edges);
        hold = out_state[1];
        ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_valid[1] = c[0];
            in_state[1] = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(posedge clk); #1;
            if (out_state[1] !== hold || in_ready[1] !== 1'b0 || out_valid[1] !== 1'b1) ok = 1'b0;
        end
        in_valid[1] = 1'b0;
        check("bp_stable", ok, 1);
        collect(1, "bp_result");
        @(posedge clk); #1;
        check("bp_idle_after", busy[1], 0);

        // Output and input handshakes together in DONE: input taken one cycle later
        accept(2, splat(8'h00), splat(8'h63));
        wait_valid(2, edges);
        compare_out(2, "dual_first");
        in_valid[2]  = 1'b1;
        in_state[2]  = splat(8'hff);
        out_ready[2] = 1'b1;
        @(posedge clk); #1;
        out_ready[2] = 1'b0;
        check("dual_idle", busy[2], 0);
        check("dual_out_valid", out_valid[2], 0);
        @(posedge clk); #1;
        in_valid[2] = 1'b0;
        sb.push_back(splat(8'h16));
        check("dual_accepted", busy[2], 1);
        wait_valid(2, edges);
        collect(2, "dual_second");

        // Reset in the middle of RUN on BPC=1
        in_valid[0] = 1'b1;
        in_state[0] = FipsIn;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid[0], 0);
        check("mid_rst_out_state", out_state[0], 0);
        check("mid_rst_busy", busy[0], 0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_block(0, splat(8'h53), splat(8'hed), "after_abort");

        // Back-to-back on BPC=4 with in_valid and out_ready held high
        blk[0] = FipsIn;
        blk[1] = splat(8'h19);
        blk[2] = splat(8'h00);
        k = 0;
        nout = 0;
        out_ready[1] = 1'b1;
        for (int c = 0; c < 100 && nout < 3; c++) begin
            in_valid[1] = (k < 3);
            if (k < 3) in_state[1] = blk[k];
            acc = in_valid[1] && in_ready[1];
            if (out_valid[1]) begin
                compare_out(1, $sformatf("b2b%0d", nout));
                times[nout] = c;
                nout++;
            end
            @(posedge clk); #1;
            if (acc) begin
                sb.push_back((k == 0) ? FipsOut : (k == 1) ? splat(8'hd4) : splat(8'h63));
                k++;
            end
        end
        in_valid[1]  = 1'b0;
        out_ready[1] = 1'b0;
        check("b2b_count", nout, 3);
        if (nout == 3) begin
            check("b2b_gap01", times[1] - times[0], groups_of(1) + 2);
            check("b2b_gap12", times[2] - times[1], groups_of(1) + 2);
        end
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
